kernel_bias_loader: RTL and testbench

//  Upstream write-side feeder for the kernel-bias BRAM bank. Accepts a valid/ready word stream of packed

---
 rtl/kernel_bias_loader.sv | 213 +++++++++++++++++++++
 tb/tb_kernel_bias_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_bias_loader.sv
// kernel_bias_loader
//   Write-side feeder for the kernel-bias BRAM bank. It takes a valid/ready
//   stream of packed bias words and writes them in order: BRAM 0 is filled
//   first, then BRAM 1, and so on. Each BRAM receives W = ceil(size/PPW) words.
//   No stream words are accepted while the bank reports reset-busy.
//   Every load ends with exactly one o_done or o_error pulse, except when it
//   is cut short by i_reset.
// Ports
//   i_clock, i_reset        clock (rising edge); asynchronous active-high reset
//   i_start                 one-cycle load request, sampled only in IDLE
//   i_kernel_bias_size      bias points per BRAM, latched at start
//   i_reset_busy            bank reset in progress; stalls loading
//   i_s_valid/i_s_data/i_s_last, o_s_ready   input word stream
//   o_wenable/o_waddress/o_bram_data         per-BRAM write port (registered)
//   o_busy, o_done, o_error                  load status (registered)
module kernel_bias_loader #(
  parameter int DATA_WIDTH                     = 32,
  parameter int KERNEL_FILTER_WIDTH            = 8,
  parameter int KERNEL_BRAM_NUM                = 4,
  parameter int KERNEL_BIAS_WIDTH              = KERNEL_FILTER_WIDTH,
  parameter int KERNEL_BIAS_BRAM_ADDRESS_WIDTH = 1,
  parameter int POINTS_PER_WORD                = 4
) (
  input  logic                                                           i_clock,
  input  logic                                                           i_reset,
  input  logic                                                           i_start,
  input  logic [KERNEL_BIAS_WIDTH-1:0]                                   i_kernel_bias_size,
  input  logic                                                           i_reset_busy,
  input  logic                                                           i_s_valid,
  input  logic [DATA_WIDTH-1:0]                                          i_s_data,
  input  logic                                                           i_s_last,
  output logic                                                           o_s_ready,
  output logic [KERNEL_BRAM_NUM-1:0]                                     o_wenable,
  output logic [KERNEL_BRAM_NUM-1:0][KERNEL_BIAS_BRAM_ADDRESS_WIDTH-1:0] o_waddress,
  output logic [KERNEL_BRAM_NUM-1:0][DATA_WIDTH-1:0]                     o_bram_data,
  output logic                                                           o_busy,
  output logic                                                           o_done,
  output logic                                                           o_error
);

  localparam int AW       = KERNEL_BIAS_BRAM_ADDRESS_WIDTH;
  localparam int WW       = KERNEL_BIAS_WIDTH + 1;  // one extra bit so the ceil add never overflows
  localparam int LOG2_PPW = $clog2(POINTS_PER_WORD);
  localparam int BIW      = (KERNEL_BRAM_NUM > 1) ? $clog2(KERNEL_BRAM_NUM) : 1;
  localparam logic [BIW-1:0] LAST_BRAM   = BIW'(KERNEL_BRAM_NUM - 1);
  localparam logic [63:0]    BRAM_DEPTH  = 64'd1 << AW;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHECK    = 2'd1,
    S_WAIT_RST = 2'd2,
    S_LOAD     = 2'd3
  } state_t;

  state_t                                   state_q, state_d;
  logic [KERNEL_BIAS_WIDTH-1:0]             size_q, size_d;
  logic [BIW-1:0]                           bram_q, bram_d;
  logic [AW-1:0]                            addr_q, addr_d;
  logic                                     load_q, load_d;
  logic [KERNEL_BRAM_NUM-1:0]               wen_q, wen_d;
  logic [KERNEL_BRAM_NUM-1:0][AW-1:0]       waddr_q, waddr_d;
  logic [KERNEL_BRAM_NUM-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                                     busy_q, busy_d;
  logic                                     done_q, done_d;
  logic                                     error_q, error_d;

  logic [WW-1:0] w_s;
  logic [63:0]   w_ext_s;
  logic          addr_end_s;
  logic          last_word_s;
  logic          accept_s;

  // Words per BRAM (ceil division) and position of the current word in the load.
  assign w_s         = WW'(({1'b0, size_q} + WW'(POINTS_PER_WORD - 1)) >> LOG2_PPW);
  assign w_ext_s     = 64'(w_s);
  assign addr_end_s  = (64'(addr_q) == (w_ext_s - 64'd1));
  assign last_word_s = (bram_q == LAST_BRAM) && addr_end_s;

  // Ready is the registered LOAD flag, gated combinationally by bank busy.
  assign o_s_ready = load_q & ~i_reset_busy;
  assign accept_s  = o_s_ready & i_s_valid;

  assign o_wenable   = wen_q;
  assign o_waddress  = waddr_q;
  assign o_bram_data = wdata_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_error     = error_q;

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_CHECK;
        else         state_d = S_IDLE;
      end
      S_CHECK: begin
        if ((w_ext_s > BRAM_DEPTH) || (w_ext_s == 64'd0)) state_d = S_IDLE;
        else                                              state_d = S_WAIT_RST;
      end
      S_WAIT_RST: begin
        if (i_reset_busy) state_d = S_WAIT_RST;
        else              state_d = S_LOAD;
      end
      S_LOAD: begin
        // Either a clean final word or a misplaced/missing last ends the load.
        if (accept_s && (i_s_last || last_word_s)) state_d = S_IDLE;
        else                                       state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic: counters, write port, status pulses.
  always_comb begin
    size_d  = size_q;
    bram_d  = bram_q;
    addr_d  = addr_q;
    wen_d   = '0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    load_d  = (state_d == S_LOAD);
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          size_d = i_kernel_bias_size;
          bram_d = '0;
          addr_d = '0;
        end else begin
          size_d = size_q;
        end
      end
      S_CHECK: begin
        if (w_ext_s > BRAM_DEPTH) begin
          error_d = 1'b1;
        end else if (w_ext_s == 64'd0) begin
          done_d = 1'b1;
        end else begin
          error_d = 1'b0;
        end
      end
      S_WAIT_RST: begin
        wen_d = '0;
      end
      S_LOAD: begin
        if (accept_s) begin
          if (i_s_last != last_word_s) begin
            // Word is dropped; the load is aborted.
            error_d = 1'b1;
          end else begin
            wen_d[bram_q]   = 1'b1;
            waddr_d[bram_q] = addr_q;
            wdata_d[bram_q] = i_s_data;
            if (last_word_s) begin
              done_d = 1'b1;
            end else if (addr_end_s) begin
              addr_d = '0;
              bram_d = bram_q + BIW'(1);
            end else begin
              addr_d = addr_q + AW'(1);
            end
          end
        end else begin
          wen_d = '0;
        end
      end
      default: begin
        wen_d = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      size_q  <= '0;
      bram_q  <= '0;
      addr_q  <= '0;
      load_q  <= 1'b0;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      size_q  <= size_d;
      bram_q  <= bram_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_kernel_bias_loader.sv
// tb_kernel_bias_loader
//   Directed bench for kernel_bias_loader with NUM=4, AW=1, PPW=4, DATA=32.
//   Word k of a load goes to BRAM k/2, address k%2 when W=2.
module tb_kernel_bias_loader;

  logic              clk;
  logic              i_reset;
  logic              i_start;
  logic [7:0]        i_kernel_bias_size;
  logic              i_reset_busy;
  logic              i_s_valid;
  logic [31:0]       i_s_data;
  logic              i_s_last;
  logic              o_s_ready;
  logic [3:0]        o_wenable;
  logic [3:0][0:0]   o_waddress;
  logic [3:0][31:0]  o_bram_data;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Observed BRAM contents and event counters, collected at the falling edge.
  logic [31:0] mem [4][2];
  int strobe_cnt = 0;
  int multi_cnt  = 0;
  int done_cnt   = 0;
  int err_cnt    = 0;
  int both_cnt   = 0;
  int ready_cnt  = 0;

  kernel_bias_loader #(
    .DATA_WIDTH(32), .KERNEL_FILTER_WIDTH(8), .KERNEL_BRAM_NUM(4),
    .KERNEL_BIAS_WIDTH(8), .KERNEL_BIAS_BRAM_ADDRESS_WIDTH(1), .POINTS_PER_WORD(4)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_kernel_bias_size(i_kernel_bias_size), .i_reset_busy(i_reset_busy),
    .i_s_valid(i_s_valid), .i_s_data(i_s_data), .i_s_last(i_s_last),
    .o_s_ready(o_s_ready), .o_wenable(o_wenable), .o_waddress(o_waddress),
    .o_bram_data(o_bram_data), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor.
  always @(negedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (o_wenable[b]) begin
        mem[b][o_waddress[b]] = o_bram_data[b];
        strobe_cnt++;
      end
    end
    if ($countones(o_wenable) > 1) multi_cnt++;
    if (o_done) done_cnt++;
    if (o_error) err_cnt++;
    if (o_done && o_error) both_cnt++;
    if (o_s_ready) ready_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] size);
    i_start = 1'b1;
    i_kernel_bias_size = size;
    tick();
    i_start = 1'b0;
  endtask

  // Offer one word and wait (bounded) for it to be accepted.
  task automatic send_word(input logic [31:0] data, input logic last, input bit gaps);
    bit got;
    if (gaps) begin
      i_s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    i_s_valid = 1'b1;
    i_s_data  = data;
    i_s_last  = last;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (o_s_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    i_s_valid = 1'b0;
    i_s_last  = 1'b0;
    if (!got) chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wen"}, 64'(o_wenable), 64'd0);
    chk({tag, "_waddr"}, 64'(o_waddress), 64'd0);
    for (int b = 0; b < 4; b++) chk($sformatf("%s_data%0d", tag, b), 64'(o_bram_data[b]), 64'd0);
    chk({tag, "_ready"}, 64'(o_s_ready), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_error"}, 64'(o_error), 64'd0);
  endtask

  // Checks for a load whose 8th (final) word was just accepted at the last edge.
  task automatic finish_checks(input string tag, input logic [31:0] base,
                               input int s_str, input int s_done, input int s_err);
    chk({tag, "_done_pulse"}, 64'(o_done), 64'd1);
    chk({tag, "_err_low"}, 64'(o_error), 64'd0);
    chk({tag, "_last_wen"}, 64'(o_wenable), 64'b1000);
    chk({tag, "_last_addr"}, 64'(o_waddress[3]), 64'd1);
    chk({tag, "_last_data"}, 64'(o_bram_data[3]), 64'(base + 32'd7));
    chk({tag, "_busy_low"}, 64'(o_busy), 64'd0);
    tick();
    chk({tag, "_done_gone"}, 64'(o_done), 64'd0);
    chk({tag, "_wen_gone"}, 64'(o_wenable), 64'd0);
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 2; a++) begin
        chk($sformatf("%s_mem_b%0d_a%0d", tag, b, a), 64'(mem[b][a]), 64'(base + 32'(2 * b + a)));
      end
    end
    chk({tag, "_strobes"}, 64'(strobe_cnt - s_str), 64'd8);
    chk({tag, "_done_cnt"}, 64'(done_cnt - s_done), 64'd1);
    chk({tag, "_err_cnt"}, 64'(err_cnt - s_err), 64'd0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] size, input logic [31:0] base, input bit gaps);
    int s_str;
    int s_done;
    int s_err;
    s_str = strobe_cnt; s_done = done_cnt; s_err = err_cnt;
    do_start(size);
    chk({tag, "_busy_start"}, 64'(o_busy), 64'd1);
    for (int k = 0; k < 8; k++) send_word(base + 32'(k), (k == 7), gaps);
    finish_checks(tag, base, s_str, s_done, s_err);
  endtask

  initial begin
    int s_str;
    int s_done;
    int s_err;
    int s_rdy;

    i_reset = 1'b1; i_start = 1'b0; i_kernel_bias_size = 8'd0; i_reset_busy = 1'b0;
    i_s_valid = 1'b0; i_s_data = 32'd0; i_s_last = 1'b0;
    tick(); tick();
    check_zero("reset");
    i_reset = 1'b0;
    tick();

    // Clean load, size=8 -> W=2.
    run_load("sz8", 8'd8, 32'hA0, 1'b0);

    // size=5 -> W=2, same layout.
    run_load("sz5", 8'd5, 32'hB0, 1'b0);

    // size=9 -> W=3 exceeds depth 2: error two cycles after start.
    s_str = strobe_cnt; s_rdy = ready_cnt; s_done = done_cnt;
    i_s_valid = 1'b1; i_s_data = 32'h55;
    do_start(8'd9);
    chk("sz9_err_early", 64'(o_error), 64'd0);
    tick();
    chk("sz9_err_pulse", 64'(o_error), 64'd1);
    chk("sz9_done_low", 64'(o_done), 64'd0);
    chk("sz9_busy_low", 64'(o_busy), 64'd0);
    tick();
    chk("sz9_err_gone", 64'(o_error), 64'd0);
    i_s_valid = 1'b0;
    chk("sz9_no_strobe", 64'(strobe_cnt - s_str), 64'd0);
    chk("sz9_no_ready", 64'(ready_cnt - s_rdy), 64'd0);
    chk("sz9_no_done", 64'(done_cnt - s_done), 64'd0);

    // size=0 -> W=0: done two cycles after start, nothing accepted.
    s_str = strobe_cnt; s_rdy = ready_cnt; s_err = err_cnt;
    i_s_valid = 1'b1;
    do_start(8'd0);
    chk("sz0_done_early", 64'(o_done), 64'd0);
    tick();
    chk("sz0_done_pulse", 64'(o_done), 64'd1);
    chk("sz0_err_low", 64'(o_error), 64'd0);
    tick();
    chk("sz0_done_gone", 64'(o_done), 64'd0);
    i_s_valid = 1'b0;
    chk("sz0_no_strobe", 64'(strobe_cnt - s_str), 64'd0);
    chk("sz0_no_ready", 64'(ready_cnt - s_rdy), 64'd0);
    chk("sz0_no_err", 64'(err_cnt - s_err), 64'd0);

    // Bank busy for 5 cycles after start and 3 cycles mid-load.
    s_str = strobe_cnt; s_done = done_cnt; s_err = err_cnt;
    i_reset_busy = 1'b1;
    i_s_valid = 1'b1; i_s_data = 32'hC0; i_s_last = 1'b0;
    do_start(8'd8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rbusy_start_ready%0d", i), 64'(o_s_ready), 64'd0);
      chk($sformatf("rbusy_start_wen%0d", i), 64'(o_wenable), 64'd0);
      tick();
    end
    chk("rbusy_start_nostrobe", 64'(strobe_cnt - s_str), 64'd0);
    i_reset_busy = 1'b0;
    for (int k = 0; k < 3; k++) send_word(32'hC0 + 32'(k), 1'b0, 1'b0);
    i_reset_busy = 1'b1;
    i_s_valid = 1'b1; i_s_data = 32'hC3; i_s_last = 1'b0;
    #1;
    chk("rbusy_mid_ready", 64'(o_s_ready), 64'd0);
    chk("rbusy_mid_prior_strobe", 64'(o_wenable), 64'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rbusy_mid_wen%0d", i), 64'(o_wenable), 64'd0);
    end
    i_reset_busy = 1'b0;
    for (int k = 3; k < 8; k++) send_word(32'hC0 + 32'(k), (k == 7), 1'b0);
    finish_checks("rbusy", 32'hC0, s_str, s_done, s_err);

    // Early last on the 3rd word: two writes, then error.
    s_str = strobe_cnt; s_done = done_cnt; s_err = err_cnt;
    do_start(8'd8);
    send_word(32'hE0, 1'b0, 1'b0);
    send_word(32'hE1, 1'b0, 1'b0);
    send_word(32'hE2, 1'b1, 1'b0);
    chk("early_err_pulse", 64'(o_error), 64'd1);
    chk("early_no_wen", 64'(o_wenable), 64'd0);
    chk("early_busy_low", 64'(o_busy), 64'd0);
    chk("early_done_low", 64'(o_done), 64'd0);
    tick();
    chk("early_err_gone", 64'(o_error), 64'd0);
    chk("early_strobes", 64'(strobe_cnt - s_str), 64'd2);
    chk("early_err_cnt", 64'(err_cnt - s_err), 64'd1);
    chk("early_done_cnt", 64'(done_cnt - s_done), 64'd0);

    // Missing last on the 8th word: seven writes, then error.
    s_str = strobe_cnt; s_done = done_cnt; s_err = err_cnt;
    do_start(8'd8);
    for (int k = 0; k < 8; k++) send_word(32'hF0 + 32'(k), 1'b0, 1'b0);
    chk("nolast_err_pulse", 64'(o_error), 64'd1);
    chk("nolast_no_wen", 64'(o_wenable), 64'd0);
    chk("nolast_done_low", 64'(o_done), 64'd0);
    tick();
    chk("nolast_strobes", 64'(strobe_cnt - s_str), 64'd7);
    chk("nolast_err_cnt", 64'(err_cnt - s_err), 64'd1);
    chk("nolast_done_cnt", 64'(done_cnt - s_done), 64'd0);

    // Valid gaps, async reset after the 4th word, then a clean load.
    do_start(8'd8);
    for (int k = 0; k < 4; k++) send_word(32'h10 + 32'(k), 1'b0, 1'b1);
    i_reset = 1'b1;
    #1;
    check_zero("arst");
    s_done = done_cnt; s_err = err_cnt;
    tick(); tick();
    i_reset = 1'b0;
    tick(); tick();
    chk("arst_silent_done", 64'(done_cnt - s_done), 64'd0);
    chk("arst_silent_err", 64'(err_cnt - s_err), 64'd0);
    run_load("post_rst", 8'd8, 32'hD0, 1'b1);

    chk("never_multi_strobe", 64'(multi_cnt), 64'd0);
    chk("never_done_and_err", 64'(both_cnt), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
